// File: rtl/alu_mp_ctrl_if.sv
// Upstream instruction/result interface of the multi-cycle execute controller.
//
// Handshake: an instruction transfers on a rising clk edge where both
// instr_valid and instr_ready are high. The master holds instr stable while
// instr_valid is high. instr_ready is high only while the controller is idle,
// and instr_valid is ignored while instr_ready is low. result/flags are held
// until the next execute; done and err are single-cycle pulses.
interface alu_mp_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;
  logic              flag_v;
  logic              done;
  logic              err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, result, flag_z, flag_c, flag_v, done, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, result, flag_z, flag_c, flag_v, done, err
  );
endinterface

// File: rtl/alu_mp_ctrl.sv
// Multi-cycle execute controller in front of reg_file.
// Sequence per instruction: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE.
// reg_file read is registered, so addresses go out at the end of DECODE and
// data is sampled in EXEC. All outputs are registered.
module alu_mp_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  alu_mp_ctrl_if.slave      bus,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [2:0]        dbg_state,
  output logic [31:0]       dbg_instr
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state;

  logic [31:0]       instr_q;
  logic              instr_ready_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic              flag_v_q;
  logic              done_q;
  logic              err_q;

  // Instruction fields of the latched instruction
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;

  assign op  = instr_q[31 -: OP_W];
  assign rs1 = instr_q[25 -: ADDR_W];
  assign rs2 = instr_q[20 -: ADDR_W];
  assign rd  = instr_q[15 -: ADDR_W];

  // Shared adder: SUB is A + ~B + 1 so carry out means no-borrow
  logic              is_sub;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~rf_rdata2 : rf_rdata2;
  assign sum    = {1'b0, rf_rdata1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  // ALU result and carry/overflow for the latched opcode
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (rf_rdata1[DATA_W-1] == b_eff[DATA_W-1]) &&
                  (sum[DATA_W-1] != rf_rdata1[DATA_W-1]);
      end
      OP_AND:  alu_res = rf_rdata1 & rf_rdata2;
      OP_OR:   alu_res = rf_rdata1 | rf_rdata2;
      OP_XOR:  alu_res = rf_rdata1 ^ rf_rdata2;
      OP_SLL:  alu_res = rf_rdata1 << rf_rdata2[SH_W-1:0];
      OP_SRL:  alu_res = rf_rdata1 >> rf_rdata2[SH_W-1:0];
      OP_SLT:  alu_res = ($signed(rf_rdata1) < $signed(rf_rdata2)) ?
                         {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      OP_PASS: alu_res = rf_rdata1;
      default: alu_res = '0;
    endcase
  end

  // Controller FSM with registered outputs; reset aborts any write in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b1;
      rf_addr1      <= '0;
      rf_addr2      <= '0;
      rf_addr3      <= '0;
      rf_we         <= 1'b0;
      rf_wdata      <= '0;
      result_q      <= '0;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      flag_v_q      <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rf_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid && instr_ready_q) begin
            instr_q       <= bus.instr;
            instr_ready_q <= 1'b0;
            state         <= DECODE;
          end
        end
        DECODE: begin
          rf_addr1 <= rs1;
          rf_addr2 <= rs2;
          if (op > OP_PASS) begin
            err_q         <= 1'b1;
            instr_ready_q <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          result_q <= alu_res;
          flag_z_q <= (alu_res == '0);
          flag_c_q <= alu_c;
          flag_v_q <= alu_v;
          rf_we    <= 1'b1;
          rf_addr3 <= rd;
          rf_wdata <= alu_res;
          done_q   <= 1'b1;
          state    <= WB;
        end
        WB: begin
          instr_ready_q <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          instr_ready_q <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.result      = result_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;
  assign bus.flag_v      = flag_v_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign dbg_state       = state;
  assign dbg_instr       = instr_q;

endmodule

// File: tb/tb_alu_mp_ctrl.sv
// Bench for alu_mp_ctrl: vector table of instructions plus hand-written
// sequences for illegal opcodes and reset during write-back. A small
// registered-read reg_file model closes the loop.
module tb_alu_mp_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_addr1, rf_addr2, rf_addr3;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  dbg_state;
  logic [31:0] dbg_instr;

  alu_mp_ctrl_if #(.DATA_W(32)) bus ();

  alu_mp_ctrl #(.DATA_W(32), .ADDR_W(5), .OP_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rf_addr1  (rf_addr1),
    .rf_addr2  (rf_addr2),
    .rf_addr3  (rf_addr3),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .dbg_state (dbg_state),
    .dbg_instr (dbg_instr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reg_file model ----------------
  logic [31:0] regs [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_addr1];
    rf_rdata2 <= regs[rf_addr2];
    if (pre_we) regs[pre_addr] <= pre_data;
    if (rf_we)  regs[rf_addr3] <= rf_wdata;
  end

  // ---------------- scoreboard ----------------
  // entry: {rd, z, c, v, result}
  logic [39:0] exp_q[$];
  logic [39:0] mon_exp;
  int checks = 0;
  int errors = 0;
  time acc_time;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop and compare on every write-back pulse
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("wb_rd_flags_result", {24'h0, rf_addr3, bus.flag_z, bus.flag_c, bus.flag_v, bus.result}, {24'h0, mon_exp});
        chk("wb_wdata", rf_wdata, mon_exp[31:0]);
        chk("wb_we", rf_we, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input bit push, input logic [39:0] e,
                       output int lat, output bit got_done, output bit got_err, output bit saw_we);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_issue", bus.instr_ready, 1);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    acc_time = $time;
    #1 bus.instr_valid = 1'b0;
    got_done = 0; got_err = 0; saw_we = 0; lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rf_we) saw_we = 1;
      if (bus.done || bus.err) begin
        lat = n; got_done = bus.done; got_err = bus.err;
        break;
      end
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    bit          load;
    logic [31:0] a, b, exp_r;
    bit          z, c, v;
  } vec_t;

  vec_t vecs [14];

  int  lat;
  bit  gd, ge, gw, saw;
  time t1, t2;

  initial begin
    vecs[0]  = '{6'd0, 5'd5,  5'd10, 5'd3,  1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{6'd1, 5'd3,  5'd4,  5'd0,  1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{6'd8, 5'd0,  5'd1,  5'd2,  1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'd5, 5'd6,  5'd7,  5'd8,  1'b1, 32'h80000000, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'd6, 5'd6,  5'd7,  5'd9,  1'b0, 32'h0,        32'h0,        32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'd7, 5'd11, 5'd12, 5'd10, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'd2, 5'd13, 5'd14, 5'd15, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'd3, 5'd13, 5'd14, 5'd16, 1'b0, 32'h0,        32'h0,        32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'd4, 5'd13, 5'd14, 5'd17, 1'b0, 32'h0,        32'h0,        32'hFF00FF00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'd0, 5'd18, 5'd19, 5'd20, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{6'd1, 5'd21, 5'd22, 5'd24, 1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'd1, 5'd25, 5'd26, 5'd27, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{6'd0, 5'd23, 5'd23, 5'd23, 1'b1, 32'h00000005, 32'h00000005, 32'h0000000A, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'd0, 5'd23, 5'd23, 5'd23, 1'b0, 32'h0,        32'h0,        32'h00000014, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_result", bus.result, 0);
    rst = 1'b0;

    // Idle with no valid: no writes, no pulses
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (rf_we || bus.done || bus.err) saw = 1;
    end
    chk("idle_quiet", saw, 0);

    // r0 starts non-zero so the SUB write to r0 is visible later
    preload(5'd0, 32'h0000DEAD);

    foreach (vecs[i]) begin
      if (vecs[i].load) begin
        preload(vecs[i].rs1, vecs[i].a);
        preload(vecs[i].rs2, vecs[i].b);
      end
      issue({vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 11'h0}, 1,
            {vecs[i].rd, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].exp_r},
            lat, gd, ge, gw);
      chk("latency", lat, 3);
      chk("no_err_legal", ge, 0);
    end

    // Illegal opcodes 0x3F and 9: err one cycle after DECODE, no write
    issue(32'hFC000000, 0, '0, lat, gd, ge, gw);
    chk("ill3f_err_lat", lat, 1);
    chk("ill3f_err", ge, 1);
    chk("ill3f_ready", bus.instr_ready, 1);
    chk("ill3f_result_kept", bus.result, 32'h00000014);
    issue({6'd9, 5'd1, 5'd2, 5'd3, 11'h0}, 0, '0, lat, gd, ge, gw);
    chk("ill9_err_lat", lat, 1);
    chk("ill9_err", ge, 1);
    saw = gw;
    repeat (4) begin
      @(negedge clk);
      if (rf_we || bus.done) saw = 1;
    end
    chk("ill_no_write", saw, 0);
    chk("ill9_result_kept", bus.result, 32'h00000014);

    // Reset during WB aborts the write to r5
    preload(5'd1, 32'h00000003);
    preload(5'd2, 32'h00000004);
    preload(5'd5, 32'h00000055);
    @(negedge clk);
    bus.instr = {6'd0, 5'd1, 5'd2, 5'd5, 11'h0};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("wb_we_before_rst", rf_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_we", rf_we, 0);
    chk("rst_async_ready", bus.instr_ready, 1);
    chk("rst_async_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back after reset: r5 must still hold its old value
    issue({6'd8, 5'd5, 5'd2, 5'd6, 11'h0}, 1, {5'd6, 3'b000, 32'h00000055}, lat, gd, ge, gw);
    t1 = acc_time;
    chk("b2b1_latency", lat, 3);
    issue({6'd0, 5'd1, 5'd2, 5'd7, 11'h0}, 1, {5'd7, 3'b000, 32'h00000007}, lat, gd, ge, gw);
    t2 = acc_time;
    chk("b2b2_latency", lat, 3);
    chk("b2b_spacing", t2 - t1, 50);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
